// File: rtl/lc3b_mem_ctrl.sv
// rtl/lc3b_mem_ctrl.sv - multi-cycle MAR/MDR memory access unit with byte-lane steering
module lc3b_mem_ctrl #(
  parameter int LATENCY = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic              size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              unaligned,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-2:0] mem_addr,
  output logic [1:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;

  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              lat_we;
  logic              lat_size;
  logic              lat_unal;
  logic [DATA_W-1:0] rdata_q;

  logic              req_unal;
  logic              accept;
  logic              last_wait;
  logic [1:0]        lane_be;
  logic [DATA_W-1:0] lane_wdata;
  logic [DATA_W-1:0] lane_rdata;

  assign req_unal  = size & addr[0];
  assign accept    = (state == S_IDLE) && req;
  assign last_wait = (state == S_WAIT) && (cnt == '0);

  // Little-endian lanes: addr[0]=0 selects the low byte.
  always_comb begin
    lane_be    = 2'b11;
    lane_wdata = lat_wdata;
    lane_rdata = mem_rdata;
    if (!lat_size) begin
      lane_be    = lat_addr[0] ? 2'b10 : 2'b01;
      lane_wdata = {lat_wdata[7:0], lat_wdata[7:0]};
      lane_rdata = {8'h00, lat_addr[0] ? mem_rdata[15:8] : mem_rdata[7:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Outputs decode from state so a reset clears every RAM strobe the next cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mem_cs    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = 2'b00;
    mem_wdata = '0;
    ready     = 1'b0;
    unaligned = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (req_unal) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        mem_cs    = 1'b1;
        mem_we    = lat_we && (cnt == '0);
        mem_addr  = lat_addr[ADDR_W-1:1];
        mem_be    = lane_be;
        mem_wdata = lane_wdata;
        if (cnt == '0) begin
          state_nxt = S_DONE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_DONE: begin
        ready     = 1'b1;
        unaligned = lat_unal;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_we    <= 1'b0;
      lat_size  <= 1'b0;
      lat_unal  <= 1'b0;
    end else if (accept) begin
      lat_addr  <= addr;
      lat_wdata <= wdata;
      lat_we    <= we;
      lat_size  <= size;
      lat_unal  <= req_unal;
    end
  end

  // rdata only moves when a read finishes; writes and unaligned accesses leave it alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (last_wait && !lat_we) begin
      rdata_q <= lane_rdata;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_lc3b_mem_ctrl.sv
// tb/tb_lc3b_mem_ctrl.sv - randomized self-checking bench for lc3b_mem_ctrl
module tb_lc3b_mem_ctrl;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic        size;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        ready;
  logic        unaligned;
  logic        mem_cs;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [1:0]  mem_be;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  int checks = 0;
  int passes = 0;

  // RAM environment plus the bench's own expectation of its contents
  logic [15:0] ram   [0:32767];
  logic [15:0] model [0:32767];
  logic [15:0] exp_rdata;
  logic        poke;
  logic [14:0] poke_addr;
  logic [15:0] poke_data;

  lc3b_mem_ctrl #(.LATENCY(LAT), .ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ready(ready), .unaligned(unaligned),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = (mem_cs && !mem_we) ? ram[mem_addr] : 16'h0000;

  always @(posedge clk) begin
    if (poke) begin
      ram[poke_addr] <= poke_data;
    end else if (mem_cs && mem_we) begin
      if (mem_be[0]) ram[mem_addr][7:0]  <= mem_wdata[7:0];
      if (mem_be[1]) ram[mem_addr][15:8] <= mem_wdata[15:8];
    end
  end

  task automatic preload(input logic [14:0] wa, input logic [15:0] d);
    @(negedge clk);
    poke = 1'b1; poke_addr = wa; poke_data = d;
    @(negedge clk);
    poke = 1'b0;
    model[wa] = d;
  endtask

  // Spec-level effect of one completed access on memory and MDR.
  task automatic model_access(input logic w, input logic s, input logic [15:0] a, input logic [15:0] d);
    logic [14:0] wa;
    wa = a[15:1];
    if (s && a[0]) return;
    if (w) begin
      if (s) model[wa] = d;
      else if (a[0]) model[wa][15:8] = d[7:0];
      else model[wa][7:0] = d[7:0];
    end else begin
      if (s) exp_rdata = model[wa];
      else exp_rdata = {8'h00, a[0] ? model[wa][15:8] : model[wa][7:0]};
    end
  endtask

  task automatic do_access(input logic w, input logic s, input logic [15:0] a, input logic [15:0] d,
                           output int lat, output int cs_n, output int we_n, output int we_at,
                           output logic unal, output logic [14:0] ma, output logic [1:0] be,
                           output logic [15:0] wd);
    @(negedge clk);
    req = 1'b1; we = w; size = s; addr = a; wdata = d;
    lat = -1; cs_n = 0; we_n = 0; we_at = 0; unal = 1'b0; ma = '0; be = '0; wd = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) req = 1'b0;
      if (mem_cs) begin
        cs_n++;
        if (cs_n == 1) begin ma = mem_addr; be = mem_be; wd = mem_wdata; end
      end
      if (mem_we) begin we_n++; we_at = cs_n; end
      if (ready) begin lat = c; unal = unaligned; break; end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; req = 1'b0; we = 1'b0; size = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    checks++; if ({ready, unaligned, mem_cs, mem_we} !== 4'b0) $display("FAIL reset_strobes got=%b want=0000", {ready, unaligned, mem_cs, mem_we}); else passes++;
    checks++; if (rdata !== 16'h0) $display("FAIL reset_rdata got=%h want=0000", rdata); else passes++;
    checks++; if ({mem_addr, mem_be, mem_wdata} !== '0) $display("FAIL reset_mem_bus got=%h/%b/%h want=0", mem_addr, mem_be, mem_wdata); else passes++;
    // req together with reset must not be latched
    req = 1'b1; we = 1'b1; size = 1'b1; addr = 16'h3000; wdata = 16'h1111;
    @(negedge clk);
    reset = 1'b0; req = 1'b0;
    begin
      int seen = 0;
      repeat (8) begin
        @(negedge clk);
        if (mem_cs || ready) seen++;
      end
      checks++; if (seen !== 0) $display("FAIL reset_wins_req got=%0d active cycles want=0", seen); else passes++;
    end
    exp_rdata = 16'h0000;
  endtask

  task automatic test_word_read;
    int lat, cs_n, we_n, we_at; logic unal; logic [14:0] ma; logic [1:0] be; logic [15:0] wd;
    preload(15'h1800, 16'hBEEF);
    do_access(1'b0, 1'b1, 16'h3000, 16'h0, lat, cs_n, we_n, we_at, unal, ma, be, wd);
    model_access(1'b0, 1'b1, 16'h3000, 16'h0);
    checks++; if (lat !== LAT + 1) $display("FAIL word_read_latency got=%0d want=%0d", lat, LAT + 1); else passes++;
    checks++; if (cs_n !== LAT) $display("FAIL word_read_cs_cycles got=%0d want=%0d", cs_n, LAT); else passes++;
    checks++; if (ma !== 15'h1800) $display("FAIL word_read_mem_addr got=%h want=1800", ma); else passes++;
    checks++; if (rdata !== 16'hBEEF) $display("FAIL word_read_rdata got=%h want=beef", rdata); else passes++;
  endtask

  task automatic test_byte_read;
    int lat, cs_n, we_n, we_at; logic unal; logic [14:0] ma; logic [1:0] be; logic [15:0] wd;
    do_access(1'b0, 1'b0, 16'h3001, 16'h0, lat, cs_n, we_n, we_at, unal, ma, be, wd);
    checks++; if (be !== 2'b10) $display("FAIL byte_read_hi_be got=%b want=10", be); else passes++;
    checks++; if (rdata !== 16'h00BE) $display("FAIL byte_read_hi_rdata got=%h want=00be", rdata); else passes++;
    do_access(1'b0, 1'b0, 16'h3000, 16'h0, lat, cs_n, we_n, we_at, unal, ma, be, wd);
    checks++; if (be !== 2'b01) $display("FAIL byte_read_lo_be got=%b want=01", be); else passes++;
    checks++; if (rdata !== 16'h00EF) $display("FAIL byte_read_lo_rdata got=%h want=00ef", rdata); else passes++;
    exp_rdata = 16'h00EF;
  endtask

  task automatic test_byte_write;
    int lat, cs_n, we_n, we_at; logic unal; logic [14:0] ma; logic [1:0] be; logic [15:0] wd;
    do_access(1'b1, 1'b0, 16'h3000, 16'h0012, lat, cs_n, we_n, we_at, unal, ma, be, wd);
    model_access(1'b1, 1'b0, 16'h3000, 16'h0012);
    checks++; if (we_n !== 1 || we_at !== LAT) $display("FAIL byte_write_we got=%0d@%0d want=1@%0d", we_n, we_at, LAT); else passes++;
    checks++; if (be !== 2'b01 || wd !== 16'h1212) $display("FAIL byte_write_lanes got=%b/%h want=01/1212", be, wd); else passes++;
    checks++; if (ram[15'h1800] !== 16'hBE12) $display("FAIL byte_write_ram got=%h want=be12", ram[15'h1800]); else passes++;
    checks++; if (rdata !== exp_rdata) $display("FAIL byte_write_rdata_kept got=%h want=%h", rdata, exp_rdata); else passes++;
  endtask

  task automatic test_unaligned;
    int lat, cs_n, we_n, we_at; logic unal; logic [14:0] ma; logic [1:0] be; logic [15:0] wd;
    do_access(1'b1, 1'b1, 16'h3001, 16'hA5A5, lat, cs_n, we_n, we_at, unal, ma, be, wd);
    checks++; if (lat !== 1 || unal !== 1'b1) $display("FAIL unaligned_ready got=%0d/%b want=1/1", lat, unal); else passes++;
    checks++; if (cs_n !== 0) $display("FAIL unaligned_no_cs got=%0d want=0", cs_n); else passes++;
    @(negedge clk);
    checks++; if (ram[15'h1800] !== model[15'h1800]) $display("FAIL unaligned_ram got=%h want=%h", ram[15'h1800], model[15'h1800]); else passes++;
    checks++; if (unaligned !== 1'b0) $display("FAIL unaligned_pulse_width got=%b want=0", unaligned); else passes++;
  endtask

  task automatic test_reset_mid_write;
    int we_seen = 0;
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 1'b1; addr = 16'h3000; wdata = 16'h5555;
    @(negedge clk); req = 1'b0; if (mem_we) we_seen++;
    @(negedge clk); if (mem_we) we_seen++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_rdata = 16'h0000;
    checks++; if ({ready, unaligned, mem_cs, mem_we, mem_be} !== 6'b0 || mem_addr !== '0 || mem_wdata !== '0 || rdata !== 16'h0)
      $display("FAIL midreset_outputs got=%b%b%b%b/%b/%h/%h/%h want=all zero", ready, unaligned, mem_cs, mem_we, mem_be, mem_addr, mem_wdata, rdata);
    else passes++;
    repeat (8) begin
      @(negedge clk);
      if (mem_we || mem_cs) we_seen++;
    end
    checks++; if (we_seen !== 0) $display("FAIL midreset_no_write got=%0d want=0", we_seen); else passes++;
    checks++; if (ram[15'h1800] !== model[15'h1800]) $display("FAIL midreset_ram got=%h want=%h", ram[15'h1800], model[15'h1800]); else passes++;
  endtask

  task automatic test_back_to_back;
    int r1 = -1, r2 = -1, cs2 = -1, idle_gap = 0;
    logic [15:0] d1 = 16'hxxxx, d2 = 16'hxxxx;
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = 1'b1; addr = 16'h3000;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) addr = 16'h3002;
      if (r1 > 0 && c > r1 && r2 < 0 && !mem_cs && !ready) idle_gap++;
      if (r1 > 0 && mem_cs && cs2 < 0) begin cs2 = c; req = 1'b0; end
      if (ready) begin
        if (r1 < 0) begin r1 = c; d1 = rdata; end
        else begin r2 = c; d2 = rdata; break; end
      end
    end
    req = 1'b0;
    checks++; if (r2 - r1 !== LAT + 2) $display("FAIL b2b_spacing got=%0d want=%0d", r2 - r1, LAT + 2); else passes++;
    checks++; if (idle_gap !== 1) $display("FAIL b2b_idle_gap got=%0d want=1", idle_gap); else passes++;
    checks++; if (d1 !== model[15'h1800] || d2 !== model[15'h1801])
      $display("FAIL b2b_rdata got=%h,%h want=%h,%h", d1, d2, model[15'h1800], model[15'h1801]);
    else passes++;
    exp_rdata = model[15'h1801];
  endtask

  task automatic test_random;
    int lat, cs_n, we_n, we_at; logic unal; logic [14:0] ma; logic [1:0] be; logic [15:0] wd;
    int bad = 0;
    for (int i = 0; i < 40; i++) begin
      logic w, s, is_unal; logic [15:0] a, d;
      w = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      a = 16'h3000 + 16'($urandom_range(0, 31));
      d = 16'($urandom);
      is_unal = s && a[0];
      do_access(w, s, a, d, lat, cs_n, we_n, we_at, unal, ma, be, wd);
      model_access(w, s, a, d);
      bad = 0;
      if (lat !== (is_unal ? 1 : LAT + 1)) bad++;
      if (unal !== is_unal) bad++;
      if (cs_n !== (is_unal ? 0 : LAT)) bad++;
      if (we_n !== ((w && !is_unal) ? 1 : 0)) bad++;
      if (!is_unal) begin
        if (ma !== a[15:1]) bad++;
        if (be !== (s ? 2'b11 : (a[0] ? 2'b10 : 2'b01))) bad++;
        if (w && wd !== (s ? d : {d[7:0], d[7:0]})) bad++;
        if (w && we_at !== LAT) bad++;
      end
      checks++; if (bad !== 0) $display("FAIL rand_protocol[%0d] got=%0d errors (lat=%0d cs=%0d we=%0d be=%b) want=0", i, bad, lat, cs_n, we_n, be); else passes++;
      checks++; if (rdata !== exp_rdata) $display("FAIL rand_rdata[%0d] got=%h want=%h", i, rdata, exp_rdata); else passes++;
      @(negedge clk);
      checks++; if (ram[a[15:1]] !== model[a[15:1]]) $display("FAIL rand_ram[%0d] got=%h want=%h", i, ram[a[15:1]], model[a[15:1]]); else passes++;
    end
  endtask

  initial begin
    poke = 1'b0; poke_addr = '0; poke_data = '0;
    reset = 1'b1; req = 1'b0; we = 1'b0; size = 1'b0; addr = '0; wdata = '0;
    exp_rdata = 16'h0000;
    for (int i = 0; i < 16; i++) preload(15'h1800 + 15'(i), 16'($urandom));
    test_reset;
    test_word_read;
    test_byte_read;
    test_byte_write;
    test_unaligned;
    test_reset_mid_write;
    test_back_to_back;
    test_random;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
